// File: rtl/imm_op_pkg.sv
// Operation codes and the combinational immediate-operand datapath shared by the pipeline.
package imm_op_pkg;

  typedef enum logic [2:0] {
    OP_OR  = 3'd0,
    OP_AND = 3'd1,
    OP_XOR = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6
  } op_e;

  localparam int unsigned OP_MAX    = 6;
  localparam int unsigned N_MAX     = 64;
  localparam int unsigned DEPTH_MAX = 8;

  function automatic logic [63:0] width_mask(input int unsigned n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  // Operands arrive zero-extended to 64 bits; the result is reduced modulo 2^n.
  function automatic logic [63:0] imm_op_result(input op_e op, input logic [63:0] d,
                                                input logic [63:0] imm, input int unsigned n);
    logic [63:0] m;
    logic [63:0] res;
    m   = width_mask(n);
    res = '0;
    case (op)
      OP_OR:   res = d | imm;
      OP_AND:  res = d & imm;
      OP_XOR:  res = d ^ imm;
      OP_ADD:  res = d + imm;
      OP_SUB:  res = d - imm;
      OP_SHL:  res = (imm >= 64'(n)) ? '0 : (d << imm);
      OP_SHR:  res = (imm >= 64'(n)) ? '0 : ((d & m) >> imm);
      default: res = '0;
    endcase
    return res & m;
  endfunction

  // Carry out of bit n-1 for ADD, unsigned borrow for SUB, zero otherwise.
  function automatic logic imm_op_carry(input op_e op, input logic [63:0] d,
                                        input logic [63:0] imm, input int unsigned n);
    logic [63:0] m;
    logic [64:0] sum;
    logic [64:0] sh;
    logic        c;
    m   = width_mask(n);
    sum = {1'b0, d & m} + {1'b0, imm & m};
    sh  = sum >> n;
    case (op)
      OP_ADD:  c = sh[0];
      OP_SUB:  c = (d & m) < (imm & m);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/imm_op_pipe_if.sv
// Valid/ready stream bundle: upstream data in, downstream result plus carry out.
interface imm_op_pipe_if #(
  parameter int unsigned N = 16
);
  logic         R_IN;
  logic [N-1:0] D_IN;
  logic         RDY_OUT;
  logic         R_OUT;
  logic [N-1:0] D_OUT;
  logic         C_OUT;
  logic         RDY_IN;

  modport master (
    output R_IN, D_IN, RDY_IN,
    input  RDY_OUT, R_OUT, D_OUT, C_OUT
  );

  modport slave (
    input  R_IN, D_IN, RDY_IN,
    output RDY_OUT, R_OUT, D_OUT, C_OUT
  );
endinterface

// File: rtl/imm_op_stage.sv
// One valid/ready register slot holding an N-bit result and its carry.
module imm_op_stage #(
  parameter int unsigned N = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         i_valid,
  input  logic [N-1:0] i_data,
  input  logic         i_carry,
  output logic         o_ready,
  output logic         o_valid,
  output logic [N-1:0] o_data,
  output logic         o_carry,
  input  logic         i_ready
);

  logic         r_valid;
  logic [N-1:0] r_data;
  logic         r_carry;
  logic         w_load;

  // Loading while full is only legal when the next slot takes our token this cycle.
  assign w_load  = EN & (~r_valid | i_ready);
  assign o_ready = w_load;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_carry <= 1'b0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data  <= i_data;
        r_carry <= i_carry;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_carry = r_carry;

endmodule

// File: rtl/imm_op_pipe.sv
// Applies a fixed immediate operation on entry, then carries result and carry through DEPTH slots.
module imm_op_pipe
  import imm_op_pkg::*;
#(
  parameter int unsigned  N     = 16,
  parameter logic [N-1:0] I     = N'(1),
  parameter int unsigned  OP    = 0,
  parameter int unsigned  DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  imm_op_pipe_if.slave bus
);

  if (N < 1 || N > N_MAX) begin : g_bad_n
    $error("imm_op_pipe: N out of range");
  end
  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("imm_op_pipe: DEPTH out of range");
  end
  if (OP > OP_MAX) begin : g_bad_op
    $error("imm_op_pipe: OP not a defined operation");
  end

  localparam op_e OP_E = op_e'(OP[2:0]);

  logic [DEPTH:0] w_valid;
  logic [DEPTH:0] w_rdy;
  logic [DEPTH:0] w_carry;
  logic [N-1:0]   w_data [DEPTH+1];

  assign w_valid[0]   = bus.R_IN;
  assign w_data[0]    = N'(imm_op_result(OP_E, 64'(bus.D_IN), 64'(I), N));
  assign w_carry[0]   = imm_op_carry(OP_E, 64'(bus.D_IN), 64'(I), N);
  assign w_rdy[DEPTH] = bus.RDY_IN;

  // Ready ripples back combinationally so a draining tail frees every slot behind it.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    imm_op_stage #(.N(N)) u_stage (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN),
      .i_valid (w_valid[g]),
      .i_data  (w_data[g]),
      .i_carry (w_carry[g]),
      .o_ready (w_rdy[g]),
      .o_valid (w_valid[g+1]),
      .o_data  (w_data[g+1]),
      .o_carry (w_carry[g+1]),
      .i_ready (w_rdy[g+1])
    );
  end

  assign bus.RDY_OUT = w_rdy[0];
  assign bus.R_OUT   = w_valid[DEPTH];
  assign bus.D_OUT   = w_data[DEPTH];
  assign bus.C_OUT   = w_carry[DEPTH];

endmodule

// File: tb/tb_imm_op_pipe.sv
// Directed and randomized stimulus on four pipeline configurations checked against a token-queue model.
module tb_imm_op_pipe;

  localparam int unsigned NDUT = 4;
  localparam int unsigned OPS  [NDUT] = '{0, 3, 4, 3};
  localparam logic [15:0] IMMS [NDUT] = '{16'h0001, 16'h0001, 16'h0001, 16'hC35A};
  localparam int unsigned DEPS [NDUT] = '{2, 2, 2, 3};

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        en     = 1'b1;
  logic        r_in   = 1'b0;
  logic        rdy_in = 1'b1;
  logic [15:0] d_in   = '0;

  always #5 clk = ~clk;

  logic        rdy_o [NDUT];
  logic        r_o   [NDUT];
  logic        c_o   [NDUT];
  logic [15:0] d_o   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    imm_op_pipe_if #(.N(16)) bus ();
    assign bus.R_IN   = r_in;
    assign bus.D_IN   = d_in;
    assign bus.RDY_IN = rdy_in;
    assign rdy_o[g]   = bus.RDY_OUT;
    assign r_o[g]     = bus.R_OUT;
    assign d_o[g]     = bus.D_OUT;
    assign c_o[g]     = bus.C_OUT;

    imm_op_pipe #(.N(16), .I(IMMS[g]), .OP(OPS[g]), .DEPTH(DEPS[g])) u_dut (
      .CLK (clk),
      .RST (rst),
      .EN  (en),
      .bus (bus)
    );
  end

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  // Expected {carry, result} of every accepted token, in acceptance order, per DUT.
  logic [16:0] exp_mem [NDUT][256];
  int unsigned wr [NDUT];
  int unsigned rd [NDUT];

  function automatic logic [16:0] ref_op(input int unsigned op, input logic [15:0] imm,
                                         input logic [15:0] d);
    logic [31:0] s;
    case (op)
      0: return {1'b0, d | imm};
      1: return {1'b0, d & imm};
      2: return {1'b0, d ^ imm};
      3: begin s = 32'(d) + 32'(imm); return {s > 32'd65535, s[15:0]}; end
      4: begin s = 32'(d) - 32'(imm); return {d < imm, s[15:0]}; end
      5: return {1'b0, (imm >= 16) ? 16'h0 : (d << imm)};
      6: return {1'b0, (imm >= 16) ? 16'h0 : (d >> imm)};
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Evaluate the cycle at the falling edge, then advance past the next rising edge.
  task automatic step();
    @(negedge clk);
    if (rst) begin
      for (int k = 0; k < NDUT; k++) begin
        wr[k] = 0;
        rd[k] = 0;
      end
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        int unsigned cnt;
        logic        mrdy;
        cnt  = wr[k] - rd[k];
        mrdy = en & ((cnt < DEPS[k]) | rdy_in);
        chk($sformatf("rdy_out[%0d]", k), 32'(rdy_o[k]), 32'(mrdy));
        if (cnt == 0) begin
          chk($sformatf("r_out_empty[%0d]", k), 32'(r_o[k]), 32'd0);
        end else if (en && r_o[k] && rdy_in) begin
          chk($sformatf("out_token[%0d]", k), 32'({c_o[k], d_o[k]}),
              32'(exp_mem[k][rd[k] % 256]));
          rd[k]++;
        end
        if (en && r_in && mrdy) begin
          exp_mem[k][wr[k] % 256] = ref_op(OPS[k], IMMS[k], d_in);
          wr[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] d);
    d_in = d;
    r_in = 1'b1;
    step();
    chk("latency_early", 32'(r_o[0]), 32'd0);
    r_in = 1'b0;
    step();
  endtask

  task automatic idle(input int unsigned n);
    r_in = 1'b0;
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [15:0] e;
    for (int k = 0; k < NDUT; k++) begin
      wr[k] = 0;
      rd[k] = 0;
    end

    #1 rst = 1'b1;
    #11;
    for (int k = 0; k < NDUT; k++) begin
      chk("reset_r_out", 32'(r_o[k]), 32'd0);
      chk("reset_d_out", 32'(d_o[k]), 32'd0);
      chk("reset_c_out", 32'(c_o[k]), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_in = 1'b0;
    #1 chk("rdy_after_reset", 32'(rdy_o[0]), 32'd1);
    rdy_in = 1'b1;

    pulse(16'h0010);
    chk("or_r_out", 32'(r_o[0]), 32'd1);
    chk("or_d_out", 32'(d_o[0]), 32'h0011);
    chk("or_c_out", 32'(c_o[0]), 32'd0);

    pulse(16'hFFFF);
    chk("add_wrap_r_out", 32'(r_o[1]), 32'd1);
    chk("add_wrap_d_out", 32'(d_o[1]), 32'h0000);
    chk("add_wrap_c_out", 32'(c_o[1]), 32'd1);

    pulse(16'h0000);
    chk("sub_borrow_d_out", 32'(d_o[2]), 32'hFFFF);
    chk("sub_borrow_c_out", 32'(c_o[2]), 32'd1);
    idle(4);

    // Backpressure: only two of five offered words fit.
    rdy_in = 1'b0;
    for (int unsigned v = 1; v <= 5; v++) begin
      d_in = 16'(v);
      r_in = 1'b1;
      step();
    end
    r_in = 1'b0;
    chk("bp_rdy_out", 32'(rdy_o[0]), 32'd0);
    chk("bp_r_out", 32'(r_o[0]), 32'd1);
    chk("bp_d_out", 32'(d_o[0]), 32'h0001);
    step();
    chk("bp_hold", 32'(d_o[0]), 32'h0001);
    rdy_in = 1'b1;
    step();
    chk("bp_second_r", 32'(r_o[0]), 32'd1);
    chk("bp_second_d", 32'(d_o[0]), 32'h0003);
    step();
    chk("bp_done", 32'(r_o[0]), 32'd0);
    idle(3);

    // Continuous streaming of ten words.
    for (int unsigned i = 0; i < 12; i++) begin
      r_in = (i < 10);
      d_in = 16'h0100 + 16'(i);
      step();
      chk($sformatf("stream_r_out_%0d", i), 32'(r_o[0]), 32'((i >= 1) && (i <= 10)));
      if (i >= 1 && i <= 10) begin
        e = (16'h0100 + 16'(i - 1)) | 16'h0001;
        chk($sformatf("stream_d_out_%0d", i), 32'(d_o[0]), 32'(e));
      end
    end
    idle(3);

    // Global enable low freezes a full pipeline.
    rdy_in = 1'b0;
    r_in   = 1'b1;
    d_in   = 16'h0A00;
    step();
    d_in = 16'h0B00;
    step();
    en     = 1'b0;
    rdy_in = 1'b1;
    d_in   = 16'h0C00;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk("en_low_rdy", 32'(rdy_o[0]), 32'd0);
      chk("en_low_r_out", 32'(r_o[0]), 32'd1);
      chk("en_low_d_out", 32'(d_o[0]), 32'h0A01);
    end
    en   = 1'b1;
    r_in = 1'b0;
    step();
    chk("en_resume_d", 32'(d_o[0]), 32'h0B01);
    chk("en_resume_r", 32'(r_o[0]), 32'd1);
    step();
    chk("en_resume_done", 32'(r_o[0]), 32'd0);
    idle(4);

    // Asynchronous reset between edges with the pipeline full.
    rdy_in = 1'b0;
    r_in   = 1'b1;
    d_in   = 16'h0000;
    step();
    d_in = 16'h1234;
    step();
    r_in = 1'b0;
    chk("pre_reset_c_out", 32'(c_o[2]), 32'd1);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("async_rst_r_out", 32'(r_o[k]), 32'd0);
      chk("async_rst_d_out", 32'(d_o[k]), 32'd0);
      chk("async_rst_c_out", 32'(c_o[k]), 32'd0);
    end
    step();
    rst    = 1'b0;
    rdy_in = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk("no_stale_token", 32'(r_o[0]), 32'd0);
    end

    // Randomized traffic with random stalls and enable drops.
    for (int unsigned i = 0; i < 400; i++) begin
      en     = ($urandom_range(0, 7) != 0);
      r_in   = $urandom_range(0, 1) == 1;
      rdy_in = ($urandom_range(0, 3) != 0);
      d_in   = 16'($urandom);
      step();
    end
    en     = 1'b1;
    rdy_in = 1'b1;
    idle(6);
    for (int k = 0; k < NDUT; k++) chk($sformatf("drained[%0d]", k), 32'(r_o[k]), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imm_op_pipe.md
IMM_OP_PIPE -- requirements
Module: imm_op_pipe

Interface
REQ-001 SHALL have parameter N, default 16, data width in bits (legal 1..64).
REQ-002 SHALL have parameter I, default 1, immediate operand, N bits wide.
REQ-003 SHALL have parameter OP, default 0, operation code from the shared package (0 OR, 1 AND, 2 XOR, 3 ADD, 4 SUB, 5 SHL, 6 SHR).
REQ-004 SHALL have parameter DEPTH, default 2, number of register stages (legal 1..8).
REQ-005 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port EN  input  1  global enable; low freezes all state.
REQ-008 SHALL have port R_IN  input  1  upstream data valid.
REQ-009 SHALL have port D_IN  input  N  upstream data.
REQ-010 SHALL have port RDY_OUT  output  1  ready to upstream.
REQ-011 SHALL have port R_OUT  output  1  downstream data valid.
REQ-012 SHALL have port D_OUT  output  N  result data.
REQ-013 SHALL have port C_OUT  output  1  carry (ADD) / borrow (SUB), travels with D_OUT.
REQ-014 SHALL have port RDY_IN  input  1  downstream ready.

Function
REQ-015 Input transfer SHALL occur in a cycle iff EN & R_IN & RDY_OUT; output transfer iff EN & R_OUT & RDY_IN.
REQ-016 Operation SHALL be applied to D_IN at entry to stage 1; stages 2..DEPTH pass result and carry unchanged.
REQ-017 OR/AND/XOR: bitwise with I; C_OUT=0.
REQ-018 ADD: result = (D_IN + I) mod 2^N; C_OUT = bit N of the N+1-bit sum.
REQ-019 SUB: result = (D_IN - I) mod 2^N; C_OUT=1 iff D_IN < I (unsigned).
REQ-020 SHL/SHR: logical shift of D_IN by I; I >= N yields 0; C_OUT=0.
REQ-021 Each stage SHALL hold a valid bit; stage k SHALL load when EN and (stage k empty or stage k draining this cycle).
REQ-022 Bubbles SHALL collapse: an empty stage never blocks upstream when EN=1.
REQ-023 RDY_OUT SHALL equal EN & (stage1 empty | stage1 draining), combinational from RDY_IN through the chain.
REQ-024 Latency SHALL be exactly DEPTH cycles from input transfer to R_OUT high when never stalled.
REQ-025 Throughput SHALL be one transfer per cycle when full and RDY_IN=1 (simultaneous accept and emit).
REQ-026 With RDY_IN=0, R_OUT, D_OUT, C_OUT SHALL hold stable; pipeline SHALL accept until all DEPTH stages are full, then RDY_OUT=0.
REQ-027 With EN=0, all stage contents SHALL hold, RDY_OUT=0, no transfer counted either side; R_OUT/D_OUT keep their values.
REQ-028 Data order SHALL be preserved; no token dropped or duplicated.
REQ-029 Illegal OP, DEPTH or N SHALL fail at elaboration.

Reset
REQ-030 RST high SHALL immediately clear all valid bits, data and carry to 0 regardless of CLK or EN; R_OUT=0, D_OUT=0, C_OUT=0.
REQ-031 Reset mid-operation SHALL discard all in-flight tokens; first cycle after RST falls, RDY_OUT=EN.

Structure
REQ-032 Package imm_op_pkg SHALL hold the OP code constants and the combinational op function.
REQ-033 Sub-module imm_op_stage SHALL implement one valid/ready register stage (data N bits + carry), instantiated DEPTH times by generate.

Verification
REQ-034 OP=OR, N=16, I=1, DEPTH=2: D_IN=0x0010 one pulse, RDY_IN=1 -> R_OUT high 2 cycles later, D_OUT=0x0011, C_OUT=0.
REQ-035 OP=ADD, I=1: D_IN=0xFFFF -> D_OUT=0x0000, C_OUT=1; OP=SUB, I=1, D_IN=0x0000 -> D_OUT=0xFFFF, C_OUT=1.
REQ-036 Backpressure: RDY_IN=0, stream 0x0001..0x0005 -> exactly 2 accepted, RDY_OUT=0 after; RDY_IN=1 -> outputs 0x0001,0x0003,... in order, one per cycle.
REQ-037 Full streaming, R_IN=1, RDY_IN=1 for 10 cycles -> 10 outputs in 10 consecutive cycles after 2-cycle latency.
REQ-038 EN=0 for 3 cycles with 2 tokens in flight -> no state change, RDY_OUT=0; EN=1 -> tokens resume intact.
REQ-039 RST asserted asynchronously between edges with pipeline full -> R_OUT, D_OUT, C_OUT go 0 before next edge; no stale token emitted after release.
